// File: rtl/risc_seq.sv
// Instruction sequencer: HALT/FETCH/EXEC/FAULT control with PC update and an optional return stack.
// Define RISC_SEQ_RETSTACK_EN to build the return stack; otherwise call/return behave as sequential.
module risc_seq #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] PROG_START  = WIDTH'(16'h000F),
   parameter int               OFF_W       = 7,
   parameter int               STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             extern_halt,
   output logic             fetch_req,
   output logic [WIDTH-1:0] pc_out,
   input  logic             fetch_ack,
   input  logic [WIDTH-1:0] fetch_data,
   output logic [WIDTH-1:0] ir,
   output logic             ir_valid,
   input  logic             exec_done,
   input  logic [2:0]       branch,
   input  logic             cond,
   input  logic [WIDTH-1:0] jump_target,
   input  logic [OFF_W-1:0] offset,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             fault
);

   typedef enum logic [1:0] {
      S_HALT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic             fetch_req_q;
   logic             ir_valid_q;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] off_ext;

   assign pc_inc  = pc_q + WIDTH'(1);
   assign off_ext = {{(WIDTH-OFF_W){offset[OFF_W-1]}}, offset};

`ifdef RISC_SEQ_RETSTACK_EN
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] push_idx, pop_idx;
   logic             push, pop;
   logic             fault_q;

   assign push_idx    = cnt_q[IDX_W-1:0];
   assign pop_idx     = IDX_W'(cnt_q - CNT_W'(1));
   assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
   assign stack_empty = (cnt_q == '0);
   assign fault       = fault_q;

   always_comb begin
      cnt_d = cnt_q;
      if (push) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Stack storage carries no reset; only the occupancy count is meaningful after reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= fault_q | (state_d == S_FAULT);
      end
   end
`else
   assign stack_full  = 1'b0;
   assign stack_empty = 1'b1;
   assign fault       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
`ifdef RISC_SEQ_RETSTACK_EN
      push    = 1'b0;
      pop     = 1'b0;
`endif
      case (state_q)
         S_HALT: begin
            if (!extern_halt) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (fetch_ack) begin
               ir_d    = fetch_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               state_d = extern_halt ? S_HALT : S_FETCH;
               case (branch)
                  3'b001: pc_d = jump_target;
                  3'b010: pc_d = cond ? (pc_inc + off_ext) : pc_inc;
`ifdef RISC_SEQ_RETSTACK_EN
                  // Stack overflow/underflow freezes pc and stack and parks in FAULT.
                  3'b011: begin
                     if (stack_full) begin
                        state_d = S_FAULT;
                     end else begin
                        push = 1'b1;
                        pc_d = jump_target;
                     end
                  end
                  3'b100: begin
                     if (stack_empty) begin
                        state_d = S_FAULT;
                     end else begin
                        pop  = 1'b1;
                        pc_d = stack_q[pop_idx];
                     end
                  end
`endif
                  default: pc_d = pc_inc;
               endcase
            end
         end
         default: state_d = S_FAULT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HALT;
         pc_q        <= PROG_START;
         ir_q        <= '0;
         fetch_req_q <= 1'b0;
         ir_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         fetch_req_q <= (state_d == S_FETCH);
         ir_valid_q  <= (state_d == S_EXEC);
      end
   end

   assign fetch_req = fetch_req_q;
   assign ir_valid  = ir_valid_q;
   assign pc_out    = pc_q;
   assign ir        = ir_q;

endmodule

// File: doc/risc_seq.md
RISC_SEQ -- requirements
Module: risc_seq

Interface
REQ-001 Parameter WIDTH, default 16: width of the PC, the instruction word and jump targets.
REQ-002 Parameter PROG_START, default 16'h000F (WIDTH bits): PC value loaded at reset.
REQ-003 Parameter OFF_W, default 7: width of the signed relative branch offset.
REQ-004 Parameter STACK_DEPTH, default 4: number of return-stack entries.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 extern_halt  in  1  halt request, honoured only at instruction boundaries.
REQ-008 fetch_req  out  1  instruction fetch request, registered.
REQ-009 pc_out  out  WIDTH  current PC, also used as the fetch address.
REQ-010 fetch_ack  in  1  fetch data valid; accepted only while fetch_req=1.
REQ-011 fetch_data  in  WIDTH  instruction word, sampled when fetch_ack=1.
REQ-012 ir  out  WIDTH  latched instruction register.
REQ-013 ir_valid  out  1  high while in EXEC.
REQ-014 exec_done  in  1  execute stage finished; qualifies branch, cond, jump_target and offset.
REQ-015 branch  in  3  000 seq, 001 jump, 010 cond-relative, 011 call, 100 return, others seq.
REQ-016 cond  in  1  condition for code 010.
REQ-017 jump_target  in  WIDTH  absolute target for codes 001 and 011.
REQ-018 offset  in  OFF_W  two's-complement offset for code 010.
REQ-019 stack_full, stack_empty, fault  out  1 each  return-stack status and sticky fault.

Function
REQ-020 States HALT, FETCH, EXEC and FAULT SHALL be implemented.
- HALT->FETCH when extern_halt=0.
- FETCH->EXEC on fetch_ack.
- EXEC->FETCH, HALT or FAULT on exec_done.
- FAULT exits only on reset.
REQ-021 fetch_req SHALL be 1 exactly while in FETCH and deassert the cycle after fetch_ack.
- fetch_ack while fetch_req=0 SHALL be ignored.
REQ-022 On fetch_ack, ir SHALL load fetch_data with 1-cycle latency.
- ir SHALL hold its value outside that event.
REQ-023 On exec_done in EXEC, pc SHALL update in the same edge:
- seq: pc+1
- jump: jump_target
- cond: pc+1+sext(offset) if cond=1, else pc+1
- call: push pc+1, then pc<=jump_target
- return: pc<=pop.
REQ-024 All PC arithmetic SHALL be modulo 2^WIDTH.
- Example: pc=FFFF with seq gives 0000.
REQ-025 On exec_done with extern_halt=1, the next state SHALL be HALT after the PC update; otherwise it SHALL be FETCH.
REQ-026 A call while stack_full=1, or a return while stack_empty=1, SHALL enter FAULT.
- pc and the stack SHALL stay unchanged.
- fault SHALL be 1 from the next cycle.
REQ-027 In FAULT, fetch_req=0 and ir_valid=0, and fault=1 until reset.
REQ-028 In EXEC without exec_done, pc and all state SHALL hold.
- extern_halt SHALL not abort FETCH or EXEC.
REQ-029 stack_full SHALL be 1 when the count equals STACK_DEPTH.
- stack_empty SHALL be 1 when the count is 0.

Reset
REQ-030 On rst=1, asynchronously:
- state=HALT, pc=PROG_START, ir=0
- ir_valid=0, fetch_req=0, fault=0
- stack count=0.
REQ-031 Reset mid-fetch or mid-execute SHALL discard the pending operation.
- The first fetch after reset release SHALL be at PROG_START, once extern_halt=0.

Configuration
REQ-032 Macro RISC_SEQ_RETSTACK_EN defined: the return stack and the call/return behaviour are as above.
REQ-033 Macro RISC_SEQ_RETSTACK_EN undefined:
- no stack storage
- codes 011 and 100 act as seq
- stack_full=0 and stack_empty=1 constantly
- fault only via reset value 0.

Verification
REQ-034 Reset release, extern_halt=0, fetch_ack after 2 wait cycles with data 1234:
- fetch_req=1 with pc_out=000F until ack
- ir=1234, ir_valid=1 the next cycle.
REQ-035 pc=0020, branch=010, cond=1, offset=7'h7E (-2): pc=001F. Same with cond=0: pc=0021.
REQ-036 Calls at pc=0010 and pc=0040 to 0040 and 0080, then two returns:
- pc sequence 0040, 0080, 0041, 0011
- stack_empty=1 at the end.
REQ-037 Five calls with STACK_DEPTH=4:
- fifth call sets fault=1 and fetch_req=0
- pc equals the fifth call's own pc.
- A return on an empty stack also faults.
REQ-038 extern_halt=1 during FETCH:
- fetch completes, exec_done gives PC update and HALT
- releasing halt gives fetch at the new pc.
- Assert rst mid-EXEC: pc=000F immediately.
